// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory access unit: request size encodings,
// the controller state type and small helpers for decoding a request.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

    // Request size encodings. 2'b11 is treated as a word as well.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Both 2'b10 and 2'b11 select a full word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // A half needs addr[0]=0; a word needs addr[1:0]=0. Bytes are always aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane logic for the memory access unit.
//   - Store path: replaces the addressed byte/half lane of base_word with the
//     right-aligned store data; a word store passes wdata through.
//   - Load path: extracts the addressed lane of rd_word and zero- or
//     sign-extends it; a word load passes rd_word through.
// Ports:
//   size      in  2   request size (SZ_BYTE / SZ_HALF / word)
//   sign_ext  in  1   sign-extend extracted loads
//   addr_lo   in  2   byte address bits [1:0] selecting the lane
//   wdata     in  32  right-aligned store data
//   base_word in  32  memory word captured for read-modify-write
//   rd_word   in  32  memory word being loaded
//   merged    out 32  word to write back to memory
//   extracted out 32  extended load result
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] base_word,
    input  logic [31:0] rd_word,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output of this block gets a default up front so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        merged    = base_word;
        extracted = rd_word;
        byte_v    = rd_word[{addr_lo, 3'b000} +: 8];
        half_v    = rd_word[{addr_lo[1], 4'b0000} +: 16];

        case (size)
            SZ_BYTE: begin
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                extracted = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                // Halves use addr[1] only; addr[0] is truncated.
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                extracted = {{16{sign_ext & half_v[15]}}, half_v};
            end
            default: begin
                merged    = wdata;
                extracted = rd_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Single-outstanding load/store unit in front of a word-wide memory with a
// combinational read port and a clocked write port. Sub-word stores are done
// as read-modify-write. Loads are extracted and extended by mem_lane_align.
//
// Flows:  load        IDLE -> READ  -> RESP
//         word store  IDLE -> WRITE -> RESP
//         byte/half   IDLE -> READ  -> WRITE -> RESP
//         misaligned  IDLE -> RESP (only with MEM_ACCESS_ALIGN_CHECK_EN)
//
// Build option: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word
// requests with rsp_err=1 and no memory access. Without it, low address bits
// are truncated and rsp_err is tied to 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid  in  1            request strobe, sampled in IDLE only
//   req_ready  out 1            high while IDLE
//   req_write  in  1            1=store, 0=load
//   req_size   in  2            00 byte, 01 half, 10/11 word
//   req_signed in  1            sign-extend loads
//   req_addr   in  32           byte address
//   req_wdata  in  32           right-aligned store data
//   rsp_valid  out 1            one-cycle completion pulse (no back-pressure)
//   rsp_rdata  out 32           extended load data, 0 for stores, held otherwise
//   rsp_err    out 1            misaligned request (align check builds only)
//   mem_addr   out 32           word address during READ/WRITE, else 0
//   mem_wd     out 32           write data during WRITE, else 0
//   mem_write  out 1            high exactly during WRITE
//   mem_rd     in  32           combinational read data for mem_addr
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_write,
    input  logic [31:0] mem_rd
);

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;   // memory word captured in READ for read-modify-write

    logic [31:0] merged;
    logic [31:0] extracted;

    mem_lane_align u_align (
        .size      (size_q),
        .sign_ext  (sgn_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .base_word (rword_q),
        .rd_word   (mem_rd),
        .merged    (merged),
        .extracted (extracted)
    );

    // Memory-side outputs decode straight from the state register, so the
    // asynchronous reset forcing IDLE drops mem_write without waiting for clk.
    assign mem_write = (state == WRITE);
    assign mem_addr  = ((state == READ) || (state == WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wd    = mem_write ? merged : 32'h0;

`ifndef MEM_ACCESS_ALIGN_CHECK_EN
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            addr_q    <= 32'h0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            rword_q   <= 32'h0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        sgn_q     <= req_signed;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                        end else
`endif
                        if (req_write && is_word(req_size)) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    if (write_q) begin
                        rword_q <= mem_rd;
                        state   <= WRITE;
                    end else begin
                        rsp_rdata <= extracted;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                WRITE: begin
                    rsp_rdata <= 32'h0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    rsp_err   <= 1'b0;
`endif
                    state     <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
